// File: rtl/ntt_conf_sequencer.sv
// Command-side initiator for the mixed-radix NTT controller: steps the conf code through
// run/drain/run/drain for one forward or inverse transform, with a per-run watchdog.
module ntt_conf_sequencer #(
    parameter int unsigned DRAIN_R2 = 10,
    parameter int unsigned DRAIN_R4 = 16,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             ready,
    output logic             busy,
    output logic [3:0]       conf,
    input  logic [2:0]       done_flag,
    output logic [1:0]       phase,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned DRN_MAX = (DRAIN_R4 > DRAIN_R2) ? DRAIN_R4 : DRAIN_R2;
    localparam int unsigned CNT_MAX = (TIMEOUT > DRN_MAX) ? TIMEOUT : DRN_MAX;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DR2_LAST = CW'(DRAIN_R2 - 1);
    localparam logic [CW-1:0] DR4_LAST = CW'(DRAIN_R4 - 1);

    localparam logic [3:0] C_IDLE = 4'd0, C_R2_NTT = 4'd1, C_R4_NTT = 4'd2;
    localparam logic [3:0] C_DN_R2_NTT = 4'd3, C_DN_R4_NTT = 4'd4, C_R4_INTT = 4'd5;
    localparam logic [3:0] C_R2_INTT = 4'd6, C_DN_R2_INTT = 4'd7, C_DN_R4_INTT = 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_RUN1, S_DRN1, S_RUN2, S_DRN2, S_FIN} state_t;

    // Pass selection: {mode, second pass}. NTT runs R4 then R2, INTT runs R2 then R4.
    function automatic logic [3:0] run_code(input logic m, input logic second);
        unique case ({m, second})
            2'b00:   return C_R4_NTT;
            2'b01:   return C_R2_NTT;
            2'b10:   return C_R2_INTT;
            default: return C_R4_INTT;
        endcase
    endfunction

    function automatic logic [3:0] dn_code(input logic m, input logic second);
        unique case ({m, second})
            2'b00:   return C_DN_R4_NTT;
            2'b01:   return C_DN_R2_NTT;
            2'b10:   return C_DN_R2_INTT;
            default: return C_DN_R4_INTT;
        endcase
    endfunction

    function automatic logic [2:0] exp_flag(input logic m, input logic second);
        unique case ({m, second})
            2'b00:   return 3'b010;
            2'b01:   return 3'b001;
            2'b10:   return 3'b100;
            default: return 3'b011;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_d;
    logic [CNT_W-1:0] cycles_d;
    logic            second_q, is_r4;
    logic            ready_d, busy_d, done_d;
    logic [3:0]      conf_d;
    logic [1:0]      phase_d;

    assign second_q = (state_q == S_RUN2);
    assign is_r4    = (mode_q == second_q);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        err_d    = err;
        cycles_d = cycles;
        if (busy && (cycles != '1)) begin
            cycles_d = cycles + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start && ready) begin
                    state_d  = S_RUN1;
                    mode_d   = mode;
                    err_d    = 1'b0;
                    cycles_d = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN1, S_RUN2: begin
                // A match on the final watchdog cycle still takes priority over the timeout.
                if (done_flag == exp_flag(mode_q, second_q)) begin
                    state_d = second_q ? S_DRN2 : S_DRN1;
                    cnt_d   = is_r4 ? DR4_LAST : DR2_LAST;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRN1, S_DRN2: begin
                if (cnt_q == '0) begin
                    state_d = (state_q == S_DRN1) ? S_RUN2 : S_FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with it.
    always_comb begin
        conf_d  = C_IDLE;
        phase_d = 2'd0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            S_IDLE: ready_d = 1'b1;
            S_RUN1: begin conf_d = run_code(mode_d, 1'b0); phase_d = 2'd1; busy_d = 1'b1; end
            S_DRN1: begin conf_d = dn_code(mode_d, 1'b0);  phase_d = 2'd1; busy_d = 1'b1; end
            S_RUN2: begin conf_d = run_code(mode_d, 1'b1); phase_d = 2'd2; busy_d = 1'b1; end
            S_DRN2: begin conf_d = dn_code(mode_d, 1'b1);  phase_d = 2'd2; busy_d = 1'b1; end
            S_FIN:  begin phase_d = 2'd3; done_d = 1'b1; end
            default: ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            conf    <= C_IDLE;
            phase   <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
            err     <= 1'b0;
            cycles  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            conf    <= conf_d;
            phase   <= phase_d;
            busy    <= busy_d;
            done    <= done_d;
            ready   <= ready_d;
            err     <= err_d;
            cycles  <= cycles_d;
        end
    end

endmodule

// File: doc/ntt_conf_sequencer.md
Name: ntt_conf_sequencer

Overview:
- Command-side initiator for the mixed-radix NTT controller FSM.
- Accepts one transform request (forward NTT or inverse INTT) on a ready/start handshake.
- Drives the 4-bit conf code through run → drain → run → drain phases, and watches the controller's done_flag to advance.
- Reports completion, a watchdog error and the run cycle count to the host.

Parameters:
- DRAIN_R2, 10, cycles the DONE code is held after a radix-2 pass; must be ≥ 8-deep write pipeline + 2.
- DRAIN_R4, 16, cycles the DONE code is held after a radix-4 pass; must be ≥ 14-deep write pipeline + 2.
- TIMEOUT, 1024, maximum cycles per run phase before watchdog error.
- CNT_W, 16, width of cycle counter output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high; clock clk.
- start  in  1  request; accepted only when ready=1.
- mode  in  1  sampled on accept: 0 = forward NTT, 1 = inverse INTT.
- ready  out  1  high in IDLE only.
- busy  out  1  high from the cycle after accept through the last drain cycle.
- conf  out  4  command code to the controller FSM.
- done_flag  in  3  status code from the controller FSM.
- phase  out  2  0 idle, 1 first pass, 2 second pass, 3 finish.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky watchdog error; cleared on the next accepted start.
- cycles  out  CNT_W  busy-cycle count of the last or current job; saturates at all-ones.

Behaviour:
- Conf codes:
  - IDLE = 0, R2_NTT = 1, R4_NTT = 2, DN_R2_NTT = 3, DN_R4_NTT = 4.
  - R4_INTT = 5, R2_INTT = 6, DN_R2_INTT = 7, DN_R4_INTT = 8.
- Done codes:
  - R2_NTT → 3'b001, R4_NTT → 3'b010.
  - R2_INTT → 3'b100, R4_INTT → 3'b011.
- Pass order:
  - NTT: R4_NTT then R2_NTT.
  - INTT: R2_INTT then R4_INTT.
- States: S_IDLE, S_RUN1, S_DRN1, S_RUN2, S_DRN2, S_FIN.
- All outputs are registered.
- Reset values: conf = 0, ready = 1, busy = 0, done = 0, err = 0, phase = 0, cycles = 0, state = S_IDLE.
- S_IDLE:
  - On start & ready, latch mode, clear err and cycles, go to S_RUN1.
  - Next cycle: conf = first run code, ready = 0, busy = 1, phase = 1.
  - start while ready = 0 is ignored, not queued.
- S_RUN1 / S_RUN2:
  - Hold the run code.
  - Compare done_flag at each clk edge against the expected code for the current pass only. Other non-zero codes are ignored.
  - On match, go to S_DRNx. The next cycle's conf is the matching DONE code.
  - Load the drain counter with DRAIN_R2 or DRAIN_R4 per the pass just finished.
- S_DRNx:
  - Hold the DONE code for exactly DRAIN_* cycles.
  - Then S_DRN1 → S_RUN2 (phase = 2, conf = second run code) or S_DRN2 → S_FIN.
  - done_flag is ignored while draining.
- S_FIN (one cycle):
  - conf = 0, phase = 3, done = 1, busy = 0, then S_IDLE with ready = 1.
  - done and ready are never high in the same cycle.
- Watchdog:
  - The phase counter resets on entering each S_RUNx.
  - If it reaches TIMEOUT with no match: err = 1, conf = 0 the next cycle, go to S_FIN (done still pulses).
- Simultaneous match and timeout in the same cycle: the match wins, err stays 0.
- cycles increments every cycle busy = 1.
- Reset mid-job: all outputs return to reset values asynchronously; conf = 0 forces the controller to IDLE.
- Latency: accept → first run conf is 1 cycle; done_flag match → DONE conf is 1 cycle.

Test Plan:
- Reset held, then released: conf = 0, ready = 1, busy = 0, err = 0 until start.
- NTT job:
  - start, mode = 0; model returns 3'b010 after 512 cycles, then 3'b001 after 128 cycles.
  - conf sequence 2 → 4 (16 cycles) → 1 → 3 (10 cycles) → 0.
  - done pulses once, err = 0, cycles = 512 + 16 + 128 + 10 + 3 ± fixed offset, and the count matches the model exactly.
- INTT job:
  - start, mode = 1; model returns 3'b100, then 3'b011.
  - conf sequence 6 → 7 (10) → 5 → 8 (16) → 0; phase steps 1, 2, 3, 0.
- Spurious codes:
  - During R4_NTT the model emits 3'b001 and 3'b100.
  - Both are ignored; conf stays 2 until 3'b010.
- Watchdog:
  - The model never returns done; TIMEOUT = 1024.
  - 1024 cycles after entering RUN1: err = 1, conf = 0, done pulses. The next start clears err.
- Async rst asserted mid S_DRN1:
  - Outputs reset immediately.
  - Start asserted during busy is ignored, and a start after the abort runs a full clean job.
